// File: rtl/mem_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : mem_xbar
//  Description : NS-requester to NM-bank SRAM crossbar. Each bank owns a
//                contiguous 2^BANK_AW-byte window starting at address 0.
//                Arbitration is per bank and combinational: one grant per
//                idle bank each cycle. Losing requesters see s_busy and hold
//                their request. Read data returns one cycle after the grant.
//                Unmapped addresses are accepted at once and answered one
//                cycle later with s_err.
//
//  Ports       : clk, rst          clock / synchronous active-high reset
//                s_cs/s_we/s_addr/s_byte/s_di   requester request buses
//                s_do/s_busy/s_err              requester response buses
//                m_cs/m_we/m_addr/m_byte/m_di   bank request buses
//                m_do/m_busy                    bank response / back-pressure
//
//  Build macro : MEM_XBAR_RR_EN  defined   -> per-bank round-robin arbitration
//                                undefined -> fixed priority (lowest index wins)
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_xbar #(
    parameter int NS      = 2,
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BANK_AW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NS-1:0]        s_cs,
    input  logic [NS-1:0]        s_we,
    input  logic [NS*AW-1:0]     s_addr,
    input  logic [NS*DW/8-1:0]   s_byte,
    input  logic [NS*DW-1:0]     s_di,
    output logic [NS*DW-1:0]     s_do,
    output logic [NS-1:0]        s_busy,
    output logic [NS-1:0]        s_err,
    output logic [NM-1:0]        m_cs,
    output logic [NM-1:0]        m_we,
    output logic [NM*AW-1:0]     m_addr,
    output logic [NM*DW/8-1:0]   m_byte,
    output logic [NM*DW-1:0]     m_di,
    input  logic [NM*DW-1:0]     m_do,
    input  logic [NM-1:0]        m_busy
);

    localparam int c_BW = (NM > 1) ? $clog2(NM) : 1;   // bank index width
    localparam int c_PW = (NS > 1) ? $clog2(NS) : 1;   // requester index width
    localparam int c_SW = DW / 8;                       // strobe width

    // Bank-local offset bits; everything at or above BANK_AW is cleared.
    localparam logic [AW-1:0] c_LOCAL_MASK =
        (BANK_AW >= AW) ? {AW{1'b1}} : ((AW'(1) << BANK_AW) - AW'(1));

    // ------------------------------------------------------------------
    // Address decode per requester
    // ------------------------------------------------------------------
    logic [NS-1:0]      w_mapped;
    logic [NS*c_BW-1:0] w_bank;

    for (genvar i = 0; i < NS; i++) begin : g_dec
        logic [AW-1:0] w_a;
        assign w_a         = s_addr[i*AW +: AW];
        // Mapped iff the address lies below NM << BANK_AW.
        assign w_mapped[i] = ((w_a >> BANK_AW) < AW'(NM));

        if (NM > 1) begin : g_bidx
            assign w_bank[i*c_BW +: c_BW] = w_a[BANK_AW +: c_BW];
        end else begin : g_bidx_one
            assign w_bank[i*c_BW +: c_BW] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Per-bank arbitration
    // ------------------------------------------------------------------
    logic [NM-1:0]   w_gnt_vld;
    logic [c_PW-1:0] w_gnt_idx [NM];
    logic [NS-1:0]   w_granted;

`ifdef MEM_XBAR_RR_EN
    logic [c_PW-1:0] r_rr_ptr [NM];
`endif

    always_comb begin : p_arb
        int j;
        w_gnt_vld = '0;
        w_granted = '0;
        j         = 0;
        for (int b = 0; b < NM; b++) begin
            w_gnt_idx[b] = '0;
            // Scan order starts at the pointer (round-robin) or at index 0
            // (fixed priority); the first eligible candidate wins.
            for (int k = 0; k < NS; k++) begin
`ifdef MEM_XBAR_RR_EN
                j = int'(r_rr_ptr[b]) + k;
                if (j >= NS) begin
                    j = j - NS;
                end
`else
                j = k;
`endif
                if (!rst && !m_busy[b] && !w_gnt_vld[b] && s_cs[j] && w_mapped[j] &&
                    (int'(w_bank[j*c_BW +: c_BW]) == b)) begin
                    w_gnt_vld[b] = 1'b1;
                    w_gnt_idx[b] = c_PW'(j);
                    w_granted[j] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank-side muxing (all zero when a bank has no grant)
    // ------------------------------------------------------------------
    always_comb begin : p_bank_mux
        m_cs   = '0;
        m_we   = '0;
        m_addr = '0;
        m_byte = '0;
        m_di   = '0;
        for (int b = 0; b < NM; b++) begin
            if (w_gnt_vld[b]) begin
                m_cs[b]                  = 1'b1;
                m_we[b]                  = s_we[w_gnt_idx[b]];
                m_addr[b*AW +: AW]       = s_addr[int'(w_gnt_idx[b])*AW +: AW] & c_LOCAL_MASK;
                m_byte[b*c_SW +: c_SW]   = s_byte[int'(w_gnt_idx[b])*c_SW +: c_SW];
                m_di[b*DW +: DW]         = s_di[int'(w_gnt_idx[b])*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response state
    // ------------------------------------------------------------------
    logic [NS-1:0]   r_rd_pend;
    logic [NS-1:0]   r_err;
    logic [c_BW-1:0] r_rd_bank [NS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= '0;
            r_err     <= '0;
            for (int i = 0; i < NS; i++) begin
                r_rd_bank[i] <= '0;
            end
`ifdef MEM_XBAR_RR_EN
            for (int b = 0; b < NM; b++) begin
                r_rr_ptr[b] <= '0;
            end
`endif
        end else begin
            r_rd_pend <= w_granted & ~s_we;
            // Unmapped requests are accepted immediately and answered next cycle.
            r_err     <= s_cs & ~w_mapped;
            for (int i = 0; i < NS; i++) begin
                if (w_granted[i]) begin
                    r_rd_bank[i] <= w_bank[i*c_BW +: c_BW];
                end
            end
`ifdef MEM_XBAR_RR_EN
            for (int b = 0; b < NM; b++) begin
                if (w_gnt_vld[b]) begin
                    r_rr_ptr[b] <= (int'(w_gnt_idx[b]) == NS - 1) ? '0
                                                                  : w_gnt_idx[b] + c_PW'(1);
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Requester-side outputs
    // ------------------------------------------------------------------
    always_comb begin : p_resp
        s_do = '0;
        for (int i = 0; i < NS; i++) begin
            // rst gates the return so a read cancelled by reset shows zero
            // in the reset cycle itself.
            if (!rst && r_rd_pend[i]) begin
                s_do[i*DW +: DW] = m_do[int'(r_rd_bank[i])*DW +: DW];
            end
        end
    end

    // Only mapped, requesting, ungranted requesters are stalled; everyone is
    // stalled while in reset.
    assign s_busy = rst ? {NS{1'b1}} : (s_cs & w_mapped & ~w_granted);
    assign s_err  = r_err & {NS{~rst}};

endmodule
`default_nettype wire
